// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through
// byte FIFO with a valid/ready handshake, a frame_err pulse and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  UART_RX,
    output logic [7:0]            data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int CW    = $clog2(CLK_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]       FULL_BIT = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]       HALF_BIT = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            ferr_q, ferr_d;
    logic            rx_meta_q, rx_s_q;
    logic            tick;
    logic            push_req;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
`endif

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  pop, push_ok, full;

    // Synchroniser resets to idle-high so reset release cannot look like a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ferr_d   = 1'b0;
        push_req = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        tick = (cnt_q == '0);
        if (!tick) begin
            cnt_d = cnt_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        cnt_d   = HALF_BIT;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = FULL_BIT;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    perr_d  = rx_s_q ^ (^shift_q);
                    cnt_d   = FULL_BIT;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    cnt_d = HALF_BIT;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (perr_q) begin
                            ferr_d = 1'b1;
                        end else begin
                            push_req = 1'b1;
                        end
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                    cnt_d   = HALF_BIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign valid   = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = valid && ready;
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (push_req && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign data      = valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = ferr_q;
    assign overrun   = overrun_q;
    assign count     = count_q;

endmodule
